// File: rtl/rng_lfsr_arbiter.sv
// rng_lfsr_arbiter
//
// Owns one WIDTH-bit Fibonacci-style LFSR and shares it round-robin among
// N_REQ requesters. Each granted request clocks the LFSR STEPS times, then
// delivers the resulting word with a one-cycle one-hot GNT pulse. While the
// block is idle, a new seed can be loaded over a valid/ready handshake.
//
// Optional feature macro: RNG_WORD_COUNT_EN
//   When defined, adds a 32-bit WORD_CNT output that counts delivered words.
//   It wraps at 2^32 and clears on reset and on every accepted seed load.
//
// Ports:
//   CLK         in   system clock, rising edge
//   RESET_N     in   asynchronous active-low reset
//   SEED_VALID  in   seed load request
//   SEED_DATA   in   seed value (zero is replaced by RESET_SEED)
//   SEED_READY  out  seed accepted this cycle if SEED_VALID is high (idle only)
//   REQ         in   per-requester level request
//   GNT         out  one-hot, one-cycle grant pulse
//   RND_VALID   out  high together with the GNT pulse
//   RND_DATA    out  random word; holds its last value between grants
//   BUSY        out  high while stepping or delivering
//   WORD_CNT    out  delivered-word count (RNG_WORD_COUNT_EN only)

module rng_lfsr_arbiter #(
  parameter int               WIDTH      = 16,
  parameter int               N_REQ      = 4,
  parameter int               STEPS      = 16,
  parameter logic [WIDTH-1:0] TAPS       = 16'hB400,
  parameter logic [WIDTH-1:0] RESET_SEED = 16'hACE1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             SEED_VALID,
  input  logic [WIDTH-1:0] SEED_DATA,
  output logic             SEED_READY,
  input  logic [N_REQ-1:0] REQ,
  output logic [N_REQ-1:0] GNT,
  output logic             RND_VALID,
  output logic [WIDTH-1:0] RND_DATA,
  output logic             BUSY
`ifdef RNG_WORD_COUNT_EN
  ,
  output logic [31:0]      WORD_CNT
`endif
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_STEP = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q;
  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_next;
  logic             lfsr_ce;
  logic [CNT_W-1:0] step_cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] ptr_q;
  logic [N_REQ-1:0] gnt_q;
  logic             rnd_valid_q;
  logic [WIDTH-1:0] rnd_data_q;
  logic             grant_found;
  logic [IDX_W-1:0] grant_idx;
  logic             last_step;

  // The LFSR only advances while stepping; the shift value is computed
  // continuously so the final word can be captured on the same edge.
  assign lfsr_ce   = (state_q == ST_STEP);
  assign lfsr_next = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
  assign last_step = lfsr_ce && (step_cnt_q == '0);

  // Round-robin search: start one past the last granted index and wrap.
  // The sum is one bit wider than the index so the wrap test cannot overflow.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      logic [IDX_W:0] sum;
      sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N_REQ)) begin
        sum = sum - (IDX_W+1)'(N_REQ);
      end
      if (!grant_found && REQ[sum[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = sum[IDX_W-1:0];
      end
    end
  end

  // Control FSM, LFSR bank and registered grant/word outputs. A seed load
  // wins over a request in the same idle cycle; the request is then picked
  // up on the following cycle since REQ is a level.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      lfsr_q      <= RESET_SEED;
      step_cnt_q  <= '0;
      idx_q       <= '0;
      ptr_q       <= IDX_W'(N_REQ - 1);
      gnt_q       <= '0;
      rnd_valid_q <= 1'b0;
      rnd_data_q  <= '0;
    end else begin
      gnt_q       <= '0;
      rnd_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (SEED_VALID) begin
            lfsr_q <= (SEED_DATA == '0) ? RESET_SEED : SEED_DATA;
          end else if (grant_found) begin
            idx_q      <= grant_idx;
            step_cnt_q <= CNT_W'(STEPS - 1);
            state_q    <= ST_STEP;
          end
        end
        ST_STEP: begin
          lfsr_q <= lfsr_next;
          if (last_step) begin
            state_q     <= ST_DONE;
            gnt_q       <= N_REQ'(1) << idx_q;
            rnd_valid_q <= 1'b1;
            rnd_data_q  <= lfsr_next;
          end else begin
            step_cnt_q <= step_cnt_q - CNT_W'(1);
          end
        end
        ST_DONE: begin
          ptr_q   <= idx_q;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign SEED_READY = (state_q == ST_IDLE);
  assign BUSY       = (state_q == ST_STEP) || (state_q == ST_DONE);
  assign GNT        = gnt_q;
  assign RND_VALID  = rnd_valid_q;
  assign RND_DATA   = rnd_data_q;

`ifdef RNG_WORD_COUNT_EN
  logic [31:0] word_cnt_q;

  // Counts words as they are delivered; the increment lands with the grant
  // pulse so the count already includes the word being presented.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      word_cnt_q <= '0;
    end else if ((state_q == ST_IDLE) && SEED_VALID) begin
      word_cnt_q <= '0;
    end else if (last_step) begin
      word_cnt_q <= word_cnt_q + 32'd1;
    end
  end

  assign WORD_CNT = word_cnt_q;
`endif

endmodule

// File: tb/tb_rng_lfsr_arbiter.sv
// tb_rng_lfsr_arbiter
//
// Self-checking bench for rng_lfsr_arbiter. Two instances share clock and
// reset: dut_a uses STEPS=1 and is driven cycle by cycle from a vector
// table; dut_b uses STEPS=16 and covers fairness, spacing, seed reload and
// mid-sequence reset with hand-written sequences.
// With RNG_WORD_COUNT_EN defined the WORD_CNT outputs are checked as well.

module tb_rng_lfsr_arbiter;

  logic CLK = 1'b0;
  logic RESET_N;

  always #5 CLK = ~CLK;

  logic        a_seed_valid, b_seed_valid;
  logic [15:0] a_seed_data,  b_seed_data;
  logic        a_seed_ready, b_seed_ready;
  logic [3:0]  a_req,        b_req;
  logic [3:0]  a_gnt,        b_gnt;
  logic        a_rnd_valid,  b_rnd_valid;
  logic [15:0] a_rnd_data,   b_rnd_data;
  logic        a_busy,       b_busy;
`ifdef RNG_WORD_COUNT_EN
  logic [31:0] a_word_cnt,   b_word_cnt;
`endif

  int checks = 0;
  int passed = 0;

  rng_lfsr_arbiter #(.WIDTH(16), .N_REQ(4), .STEPS(1),
                     .TAPS(16'hB400), .RESET_SEED(16'hACE1)) dut_a (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .SEED_VALID (a_seed_valid),
    .SEED_DATA  (a_seed_data),
    .SEED_READY (a_seed_ready),
    .REQ        (a_req),
    .GNT        (a_gnt),
    .RND_VALID  (a_rnd_valid),
    .RND_DATA   (a_rnd_data),
    .BUSY       (a_busy)
`ifdef RNG_WORD_COUNT_EN
    ,
    .WORD_CNT   (a_word_cnt)
`endif
  );

  rng_lfsr_arbiter #(.WIDTH(16), .N_REQ(4), .STEPS(16),
                     .TAPS(16'hB400), .RESET_SEED(16'hACE1)) dut_b (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .SEED_VALID (b_seed_valid),
    .SEED_DATA  (b_seed_data),
    .SEED_READY (b_seed_ready),
    .REQ        (b_req),
    .GNT        (b_gnt),
    .RND_VALID  (b_rnd_valid),
    .RND_DATA   (b_rnd_data),
    .BUSY       (b_busy)
`ifdef RNG_WORD_COUNT_EN
    ,
    .WORD_CNT   (b_word_cnt)
`endif
  );

  typedef struct {
    logic        sv;
    logic [15:0] sd;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic        vld;
    logic [15:0] data;
    logic        rdy;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  // Reference LFSR advance: shift left, feedback is the XOR of tapped bits.
  function automatic logic [15:0] lfsr_adv(input logic [15:0] v, input int n);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < n; i++) begin
      r = {r[14:0], ^(r & 16'hB400)};
    end
    return r;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic sv, input logic [15:0] sd, input logic [3:0] req,
                         input logic [3:0] gnt, input logic vld, input logic [15:0] data,
                         input logic rdy, input logic busy);
    vec_t v;
    v.sv = sv; v.sd = sd; v.req = req; v.gnt = gnt;
    v.vld = vld; v.data = data; v.rdy = rdy; v.busy = busy;
    vecs.push_back(v);
  endtask

  // Drive one vector's inputs, clock once, then compare dut_a outputs.
  task automatic apply_stimulus(input int n);
    a_seed_valid = vecs[n].sv;
    a_seed_data  = vecs[n].sd;
    a_req        = vecs[n].req;
    @(posedge CLK);
    #1;
    check_output($sformatf("vec%0d gnt", n),  {28'd0, a_gnt},       {28'd0, vecs[n].gnt});
    check_output($sformatf("vec%0d vld", n),  {31'd0, a_rnd_valid}, {31'd0, vecs[n].vld});
    check_output($sformatf("vec%0d data", n), {16'd0, a_rnd_data},  {16'd0, vecs[n].data});
    check_output($sformatf("vec%0d rdy", n),  {31'd0, a_seed_ready},{31'd0, vecs[n].rdy});
    check_output($sformatf("vec%0d busy", n), {31'd0, a_busy},      {31'd0, vecs[n].busy});
  endtask

  // Wait (bounded) for a dut_b grant; returns the grant and cycles taken.
  task automatic wait_grant_b(output logic [3:0] g, output int cycles);
    g = 4'd0;
    cycles = 0;
    while (cycles < 40) begin
      @(posedge CLK);
      #1;
      cycles++;
      if (b_gnt != 4'd0) begin
        g = b_gnt;
        break;
      end
    end
  endtask

  initial begin
    logic [15:0] model_b;
    logic [3:0]  g;
    logic [3:0]  exp_g;
    int          cyc;
    int          stray;

    RESET_N      = 1'b0;
    a_seed_valid = 1'b0; a_seed_data = 16'd0; a_req = 4'd0;
    b_seed_valid = 1'b0; b_seed_data = 16'd0; b_req = 4'd0;
    repeat (2) @(posedge CLK);
    #1;
    RESET_N = 1'b1;

    check_output("rst a gnt",  {28'd0, a_gnt},        32'd0);
    check_output("rst a vld",  {31'd0, a_rnd_valid},  32'd0);
    check_output("rst a data", {16'd0, a_rnd_data},   32'd0);
    check_output("rst a rdy",  {31'd0, a_seed_ready}, 32'd1);
    check_output("rst a busy", {31'd0, a_busy},       32'd0);
    check_output("rst b gnt",  {28'd0, b_gnt},        32'd0);
    check_output("rst b rdy",  {31'd0, b_seed_ready}, 32'd1);

    // sv, seed, req  |  gnt, vld, data, rdy, busy (after the edge)
    add_vec(0, 16'h0000, 4'b0000, 4'b0000, 0, 16'h0000, 1, 0);
    add_vec(0, 16'h0000, 4'b0001, 4'b0000, 0, 16'h0000, 0, 1);
    add_vec(0, 16'h0000, 4'b0000, 4'b0001, 1, 16'h59C3, 0, 1);
    add_vec(0, 16'h0000, 4'b0000, 4'b0000, 0, 16'h59C3, 1, 0);
    add_vec(0, 16'h0000, 4'b0001, 4'b0000, 0, 16'h59C3, 0, 1);
    add_vec(0, 16'h0000, 4'b0000, 4'b0001, 1, 16'hB387, 0, 1);
    add_vec(0, 16'h0000, 4'b0000, 4'b0000, 0, 16'hB387, 1, 0);
    // zero seed reloads the reset seed
    add_vec(1, 16'h0000, 4'b0000, 4'b0000, 0, 16'hB387, 1, 0);
    add_vec(0, 16'h0000, 4'b0001, 4'b0000, 0, 16'hB387, 0, 1);
    add_vec(0, 16'h0000, 4'b0000, 4'b0001, 1, 16'h59C3, 0, 1);
    add_vec(0, 16'h0000, 4'b0000, 4'b0000, 0, 16'h59C3, 1, 0);
    // explicit seed
    add_vec(1, 16'h59C3, 4'b0000, 4'b0000, 0, 16'h59C3, 1, 0);
    add_vec(0, 16'h0000, 4'b0001, 4'b0000, 0, 16'h59C3, 0, 1);
    add_vec(0, 16'h0000, 4'b0000, 4'b0001, 1, 16'hB387, 0, 1);
    add_vec(0, 16'h0000, 4'b0000, 4'b0000, 0, 16'hB387, 1, 0);
    // seed and REQ[2] together: seed first, grant one cycle later
    add_vec(1, 16'h1234, 4'b0100, 4'b0000, 0, 16'hB387, 1, 0);
    add_vec(0, 16'h0000, 4'b0100, 4'b0000, 0, 16'hB387, 0, 1);
    add_vec(0, 16'h0000, 4'b0000, 4'b0100, 1, 16'h2469, 0, 1);
    add_vec(0, 16'h0000, 4'b0000, 4'b0000, 0, 16'h2469, 1, 0);
    // seed offered while stepping is ignored
    add_vec(0, 16'h0000, 4'b0010, 4'b0000, 0, 16'h2469, 0, 1);
    add_vec(1, 16'h0000, 4'b0000, 4'b0010, 1, 16'h48D2, 0, 1);
    add_vec(0, 16'h0000, 4'b0000, 4'b0000, 0, 16'h48D2, 1, 0);
    add_vec(0, 16'h0000, 4'b0010, 4'b0000, 0, 16'h48D2, 0, 1);
    add_vec(0, 16'h0000, 4'b0000, 4'b0010, 1, 16'h91A4, 0, 1);
    add_vec(0, 16'h0000, 4'b0000, 4'b0000, 0, 16'h91A4, 1, 0);

    for (int n = 0; n < vecs.size(); n++) begin
      apply_stimulus(n);
    end

    // Fairness and spacing on dut_b with all requests held high.
    model_b = 16'hACE1;
    b_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant_b(g, cyc);
      exp_g = 4'b0001 << (k % 4);
      model_b = lfsr_adv(model_b, 16);
      check_output($sformatf("rr%0d gnt", k), {28'd0, g}, {28'd0, exp_g});
      check_output($sformatf("rr%0d cycles", k), cyc, (k == 0) ? 32'd17 : 32'd18);
      check_output($sformatf("rr%0d vld", k), {31'd0, b_rnd_valid}, 32'd1);
      check_output($sformatf("rr%0d data", k), {16'd0, b_rnd_data}, {16'd0, model_b});
    end
    b_req = 4'b0000;
    repeat (3) @(posedge CLK);
    #1;
    check_output("rr hold data", {16'd0, b_rnd_data}, {16'd0, model_b});
    check_output("rr idle busy", {31'd0, b_busy}, 32'd0);
`ifdef RNG_WORD_COUNT_EN
    check_output("word cnt 5", b_word_cnt, 32'd5);
`endif

    // Seed load on dut_b, then one grant derived from the new seed.
    b_seed_valid = 1'b1;
    b_seed_data  = 16'h59C3;
    @(posedge CLK);
    #1;
    b_seed_valid = 1'b0;
    model_b = 16'h59C3;
`ifdef RNG_WORD_COUNT_EN
    check_output("word cnt cleared", b_word_cnt, 32'd0);
`endif
    b_req = 4'b0001;
    wait_grant_b(g, cyc);
    b_req = 4'b0000;
    model_b = lfsr_adv(model_b, 16);
    check_output("seed gnt", {28'd0, g}, 32'd1);
    check_output("seed cycles", cyc, 32'd17);
    check_output("seed data", {16'd0, b_rnd_data}, {16'd0, model_b});
    repeat (3) @(posedge CLK);
    #1;

    // Reset in the middle of a STEP sequence.
    b_req = 4'b0100;
    @(posedge CLK);
    #1;
    b_req = 4'b0000;
    repeat (5) @(posedge CLK);
    #1;
    check_output("pre-rst busy", {31'd0, b_busy}, 32'd1);
    RESET_N = 1'b0;
    #1;
    check_output("mid rst gnt",  {28'd0, b_gnt},        32'd0);
    check_output("mid rst vld",  {31'd0, b_rnd_valid},  32'd0);
    check_output("mid rst data", {16'd0, b_rnd_data},   32'd0);
    check_output("mid rst busy", {31'd0, b_busy},       32'd0);
    check_output("mid rst rdy",  {31'd0, b_seed_ready}, 32'd1);
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    stray = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge CLK);
      #1;
      if (b_gnt != 4'd0 || b_rnd_valid) stray++;
    end
    check_output("no lost grant", stray, 32'd0);

    // After reset the pointer favours requester 0 and the LFSR restarts.
    b_req = 4'b0011;
    wait_grant_b(g, cyc);
    b_req = 4'b0000;
    check_output("post rst gnt", {28'd0, g}, 32'd1);
    check_output("post rst cycles", cyc, 32'd17);
    check_output("post rst data", {16'd0, b_rnd_data}, {16'd0, lfsr_adv(16'hACE1, 16)});
    repeat (3) @(posedge CLK);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
